// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   - FSM state encoding (idle / run / done)
//   - datapath width, iteration count and counter width
//   - ALU operation codes understood by the alu sub-module
// Build option: MUL_SEQ_EARLY_TERM_EN (see mul_seq.sv) does not change anything here.
package mul_seq_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned ITER_MAX = 32;
  // Counter has to hold ITER_MAX itself, not just ITER_MAX-1.
  localparam int unsigned CNT_W    = $clog2(ITER_MAX + 1);

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared with the main datapath.
// Ports:
//   ALUop    i  operation select (AND, OR, ADD, SUB, SLT; see mul_seq_pkg)
//   A, B     i  operands
//   Result   o  operation result
//   CarryOut o  carry out of the adder (ADD), inverted borrow (SUB)
//   Overflow o  signed overflow of the adder
//   Zero     o  Result is all zeros
module alu #(
  parameter int unsigned W = 32
) (
  input  logic [2:0]   ALUop,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Result,
  output logic         CarryOut,
  output logic         Overflow,
  output logic         Zero
);
  import mul_seq_pkg::*;

  logic         sub;
  logic [W-1:0] b_eff;
  logic [W:0]   add_full;
  logic         slt;

  // One adder serves ADD, SUB and SLT; subtraction is A + ~B + 1.
  always_comb begin
    sub      = ALUop[2];
    b_eff    = B ^ {W{sub}};
    add_full = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    Overflow = (A[W-1] == b_eff[W-1]) && (add_full[W-1] != A[W-1]);
    slt      = add_full[W-1] ^ Overflow;
    CarryOut = add_full[W];
  end

  always_comb begin
    Result = '0;
    case (ALUop)
      ALUOP_AND: Result = A & B;
      ALUOP_OR:  Result = A | B;
      ALUOP_ADD: Result = add_full[W-1:0];
      ALUOP_SUB: Result = add_full[W-1:0];
      ALUOP_SLT: Result = {{(W-1){1'b0}}, slt};
      default:   Result = '0;
    endcase
    Zero = (Result == '0);
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with a 64-bit product.
// One operand pair is accepted in idle, one multiplier bit is consumed per run cycle
// using the shared alu for the partial-sum add, and the product is held in done until
// the consumer takes it.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready high only in idle)
//   a, b                multiplicand, multiplier (unsigned)
//   out_valid,out_ready product handshake (out_valid high only in done)
//   prod_hi, prod_lo    product bits 63:32 and 31:0
//   busy                high while running or holding a result
// Build option: define MUL_SEQ_EARLY_TERM_EN to finish early once the remaining
// multiplier bits are all zero (same product, shorter latency).
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy
);
  import mul_seq_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // hi holds the running partial sum; lo starts as the multiplier and fills with
  // product bits from the top as the multiplier shifts out at the bottom.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_sum;
  logic             alu_carry;
  logic             alu_overflow_unused;
  logic             alu_zero_unused;

  logic [WIDTH-1:0] step_sum;
  logic             step_carry;

`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] rem_shamt;
`endif

  alu #(
    .W (WIDTH)
  ) u_alu (
    .ALUop    (ALUOP_ADD),
    .A        (hi_q),
    .B        (mcand_q),
    .Result   (alu_sum),
    .CarryOut (alu_carry),
    .Overflow (alu_overflow_unused),
    .Zero     (alu_zero_unused)
  );

  // Partial-sum update for this cycle; the carry becomes the new top bit after the shift.
  always_comb begin
    step_sum   = hi_q;
    step_carry = 1'b0;
    if (lo_q[0]) begin
      step_sum   = alu_sum;
      step_carry = alu_carry;
    end
  end

`ifdef MUL_SEQ_EARLY_TERM_EN
  // Low (ITER_MAX - cnt) bits of lo are the multiplier bits not yet consumed.
  always_comb begin
    rem_mask  = {WIDTH{1'b1}} >> cnt_q;
    rem_shamt = CNT_W'(ITER_MAX) - cnt_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (((lo_q & rem_mask) == '0) && (cnt_q < CNT_W'(ITER_MAX))) begin
          // Nothing left to add: apply all remaining shifts at once.
          {hi_d, lo_d} = {hi_q, lo_q} >> rem_shamt;
          cnt_d        = CNT_W'(ITER_MAX);
          state_d      = StDone;
        end else
`endif
        begin
          hi_d  = {step_carry, step_sum[WIDTH-1:1]};
          lo_d  = {step_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER_MAX - 1)) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    prod_hi   = hi_q;
    prod_lo   = lo_q;
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a transaction-level model (product = a*b, done after a fixed
// number of cycles) checked every cycle, plus directed vectors with literal results.
module tb_mul_seq;

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        busy;

  always #5 clk = ~clk;

  mul_seq #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  // Number of run cycles for a given multiplier.
  function automatic int lat(input logic [31:0] bv);
    int msb;
    if (!EarlyTerm) return 32;
    if (bv == 32'd0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (bv[i]) msb = i;
    if (msb == 31) return 32;
    return msb + 2;
  endfunction

  // Transaction model: busy from accept until handshake, done after lat(b) cycles.
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_left <= lat(b);
        m_prod <= {32'd0, a} * {32'd0, b};
      end
    end else if (!m_done) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) check("product", {prod_hi, prod_lo}, m_prod);
    end
  end

  // One operation: exp_cyc is the cycle (accept edge = 0) in which out_valid first shows.
  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b, input int hold,
                       input logic [63:0] exp_prod, input int exp_cyc, input string tag);
    int guard;
    int cyc;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    a         = op_a;
    b         = op_b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " product"}, {prod_hi, prod_lo}, exp_prod);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      check({tag, " held"}, {prod_hi, prod_lo}, exp_prod);
      check({tag, " held ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          guard;
    int          tcyc;
    int          last;
    int          n;
    logic [31:0] prev_b;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst prod_hi", 64'(prod_hi), 64'd0);
    check("rst prod_lo", 64'(prod_lo), 64'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    do_op(32'd3, 32'd5, 0, 64'd15, EarlyTerm ? 5 : 33, "3x5");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 33, "max");
    do_op(32'h0001_0000, 32'h0001_0000, 10, 64'h0000_0001_0000_0000,
          EarlyTerm ? 19 : 33, "hold");

    // Reset in the middle of a run.
    a        = 32'h0000_1234;
    b        = 32'hFFFF_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    do_op(32'd7, 32'd6, 0, 64'd42, lat(32'd6) + 1, "7x6");

    do_op(32'hFFFF_FFFF, 32'd1, 0, 64'h0000_0000_FFFF_FFFF, lat(32'd1) + 1, "ones x1");
    do_op(32'h8000_0000, 32'd2, 0, 64'h0000_0001_0000_0000, lat(32'd2) + 1, "msb x2");
    do_op(32'hFFFF_FFFF, 32'd2, 1, 64'h0000_0001_FFFF_FFFE, lat(32'd2) + 1, "ones x2");
    do_op(32'h1234_5678, 32'h10, 0, 64'h0000_0001_2345_6780, lat(32'h10) + 1, "shift4");
    do_op(32'h0000_FFFF, 32'h0000_FFFF, 0, 64'h0000_0000_FFFE_0001, lat(32'hFFFF) + 1, "16sq");
    do_op(32'd0, 32'hFFFF_FFFF, 0, 64'd0, 33, "zero a");

`ifdef MUL_SEQ_EARLY_TERM_EN
    do_op(32'h1234_5678, 32'd0, 0, 64'd0, 2, "et b0");
    do_op(32'd9, 32'd1, 0, 64'd9, 3, "et 9x1");
    do_op(32'd3, 32'h8000_0000, 0, 64'h0000_0001_8000_0000, 33, "et msb");
`endif

    // Back-to-back stream with both handshakes held high.
    tcyc      = 0;
    last      = 0;
    n         = 0;
    prev_b    = '0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (n < 6 && tcyc < 400) begin
      @(negedge clk);
      tcyc++;
      if (in_ready) begin
        if (n > 0) check("stream spacing", 64'(tcyc - last), 64'(lat(prev_b) + 2));
        last     = tcyc;
        a        = $urandom;
        b        = $urandom;
        prev_b   = b;
        in_valid = 1'b1;
        n++;
      end
    end
    check("stream accepts", 64'(n), 64'd6);
    @(negedge clk);
    in_valid = 1'b0;
    guard    = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("stream drained", 64'(busy), 64'd0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
